// File: rtl/hamming_tx_scheduler.sv
// ---------------------------------------------------------------------------
// hamming_tx_scheduler
//
// Shares one Hamming(7,4) encoder among NUM_REQ nibble producers. A
// round-robin arbiter grants one valid requester at a time. The granted
// nibble is encoded and captured into a 7-bit shift register. The codeword
// is then sent LSB-first on a one-bit lane, followed by GAP_CYCLES idle cycles.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         scheduler enable; gates new grants only, never an active frame
//   req_valid  per-requester valid
//   req_data   nibble of requester i at [4i+3:4i]
//   req_ready  one-hot grant, high only in the IDLE grant cycle
//   tx_bit     serial codeword bit (LSB first)
//   tx_valid   high while tx_bit carries a codeword bit
//   tx_sof     high alongside codeword bit 0
//   tx_src     requester index of the current (or last) frame
//   busy       high while shifting or in the inter-frame gap
//
// Also holds hamming_encoder, the shared encoder used by the scheduler.
// ---------------------------------------------------------------------------

// Hamming(7,4) encoder.
//   data      nibble d3..d0
//   codeword  cw[6:0]: parity bits sit at 0, 1 and 3; data bits fill 2, 4, 5 and 6
module hamming_encoder (
  input  logic [3:0] data,
  output logic [6:0] codeword
);

  // Each parity bit covers the data bits whose codeword position has the
  // corresponding bit set in its 1-based index.
  always_comb begin
    codeword[0] = data[0] ^ data[1] ^ data[3];
    codeword[1] = data[0] ^ data[2] ^ data[3];
    codeword[2] = data[0];
    codeword[3] = data[1] ^ data[2] ^ data[3];
    codeword[4] = data[1];
    codeword[5] = data[2];
    codeword[6] = data[3];
  end

endmodule

module hamming_tx_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 1,
  parameter int SRC_W      = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [4*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_bit,
  output logic                 tx_valid,
  output logic                 tx_sof,
  output logic [SRC_W-1:0]     tx_src,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // The candidate sum rr_ptr + k needs one extra bit before it wraps.
  localparam logic [SRC_W:0]   NUM_REQ_W = (SRC_W+1)'(NUM_REQ);
  localparam logic [SRC_W-1:0] LAST_REQ  = SRC_W'(NUM_REQ - 1);
  localparam logic [3:0]       GAP_LAST  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_t           state_q,    state_d;
  logic [SRC_W-1:0] rr_ptr_q,   rr_ptr_d;
  logic [2:0]       bit_cnt_q,  bit_cnt_d;
  logic [3:0]       gap_cnt_q,  gap_cnt_d;
  logic [6:0]       shift_q,    shift_d;
  logic             tx_valid_q, tx_valid_d;
  logic             tx_sof_q,   tx_sof_d;
  logic [SRC_W-1:0] tx_src_q,   tx_src_d;

  logic             grant_vld;
  logic [SRC_W-1:0] grant_idx;
  logic [SRC_W:0]   cand_sum;
  logic [SRC_W-1:0] cand_idx;
  logic             do_grant;
  logic [3:0]       grant_nibble;
  logic [6:0]       grant_cw;

  // Round-robin search: walk the requesters starting at rr_ptr. Keep the
  // first valid one. The wrap is done by hand so that NUM_REQ need not be
  // a power of two.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_sum  = '0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
      if (cand_sum >= NUM_REQ_W) begin
        cand_sum = cand_sum - NUM_REQ_W;
      end
      cand_idx = cand_sum[SRC_W-1:0];
      if (!grant_vld && req_valid[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  // req_ready is combinational. It is forced low while reset is asserted,
  // so that every output is 0 during reset.
  assign do_grant = rst_n && (state_q == IDLE) && en && grant_vld;

  // Route the granted requester's nibble to the encoder and raise its ready.
  always_comb begin
    grant_nibble = '0;
    req_ready    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == SRC_W'(i)) begin
        grant_nibble = req_data[4*i +: 4];
        req_ready[i] = do_grant;
      end
    end
  end

  hamming_encoder u_encoder (
    .data     (grant_nibble),
    .codeword (grant_cw)
  );

  // Frame sequencing. The shift register's LSB is the lane bit itself, so
  // tx_bit is registered and shows cw[bit_cnt] while in SHIFT. Zeros
  // shifted in from the top leave the lane at 0 once the frame is done.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    shift_d    = shift_q;
    tx_valid_d = tx_valid_q;
    tx_sof_d   = tx_sof_q;
    tx_src_d   = tx_src_q;
    unique case (state_q)
      IDLE: begin
        if (do_grant) begin
          shift_d    = grant_cw;
          tx_valid_d = 1'b1;
          tx_sof_d   = 1'b1;
          tx_src_d   = grant_idx;
          rr_ptr_d   = (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
          bit_cnt_d  = 3'd0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        tx_sof_d = 1'b0;
        shift_d  = shift_q >> 1;
        if (bit_cnt_q == 3'd6) begin
          tx_valid_d = 1'b0;
          gap_cnt_d  = 4'd0;
          state_d    = (GAP_CYCLES > 0) ? GAP : IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset aborts any frame in progress and
  // discards its codeword.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      bit_cnt_q  <= 3'd0;
      gap_cnt_q  <= 4'd0;
      shift_q    <= 7'd0;
      tx_valid_q <= 1'b0;
      tx_sof_q   <= 1'b0;
      tx_src_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      shift_q    <= shift_d;
      tx_valid_q <= tx_valid_d;
      tx_sof_q   <= tx_sof_d;
      tx_src_q   <= tx_src_d;
    end
  end

  assign tx_bit   = shift_q[0];
  assign tx_valid = tx_valid_q;
  assign tx_sof   = tx_sof_q;
  assign tx_src   = tx_src_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_hamming_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_hamming_tx_scheduler
//
// Scoreboard bench for hamming_tx_scheduler. Three instances are used:
//   dut_m  GAP_CYCLES=1   frame content, enable control, reset mid-frame
//   dut_z  GAP_CYCLES=0   round-robin order/spacing and 1-cycle gap
//   dut_f  GAP_CYCLES=15  16-cycle idle run between frames
// Stimulus pushes hand-computed expectations into queues. Independent
// monitor processes pop them when the DUTs present frames or grants.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_hamming_tx_scheduler;

  typedef struct packed {
    logic [1:0] src;
    logic [6:0] cw;
    logic       aborted;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;

  logic [3:0]  m_valid;
  logic [15:0] m_data;
  logic [3:0]  m_ready;
  logic        m_bit, m_txv, m_sof, m_busy;
  logic [1:0]  m_src;

  logic [3:0]  g_valid;
  logic [15:0] g_data;
  logic [3:0]  z_ready, f_ready;
  logic        z_bit, z_txv, z_sof, z_busy;
  logic        f_bit, f_txv, f_sof, f_busy;
  logic [1:0]  z_src, f_src;

  int checks       = 0;
  int failures     = 0;
  int cycle        = 0;
  int ready_pulses = 0;

  frame_t exp_frames[$];
  int     exp_grants[$];

  hamming_tx_scheduler #(.NUM_REQ(4), .GAP_CYCLES(1)) dut_m (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(m_valid), .req_data(m_data), .req_ready(m_ready),
    .tx_bit(m_bit), .tx_valid(m_txv), .tx_sof(m_sof), .tx_src(m_src), .busy(m_busy)
  );

  hamming_tx_scheduler #(.NUM_REQ(4), .GAP_CYCLES(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(g_valid), .req_data(g_data), .req_ready(z_ready),
    .tx_bit(z_bit), .tx_valid(z_txv), .tx_sof(z_sof), .tx_src(z_src), .busy(z_busy)
  );

  hamming_tx_scheduler #(.NUM_REQ(4), .GAP_CYCLES(15)) dut_f (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(g_valid), .req_data(g_data), .req_ready(f_ready),
    .tx_bit(f_bit), .tx_valid(f_txv), .tx_sof(f_sof), .tx_src(f_src), .busy(f_busy)
  );

  // 10 ns clock with a free-running cycle count for spacing checks.
  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at cycle %0d",
               name, actual, expected, cycle);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [15:0] data);
    m_valid = valid;
    m_data  = data;
  endtask

  task automatic pushFrame(input logic [1:0] src, input logic [6:0] cw, input logic aborted);
    frame_t f;
    f.src     = src;
    f.cw      = cw;
    f.aborted = aborted;
    exp_frames.push_back(f);
  endtask

  // Waits for a grant on dut_m (use_g=0) or dut_z (use_g=1). Returns just
  // after the grant edge, so the caller may change inputs for the next cycle.
  task automatic waitGrant(input bit use_g, input int budget, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (((use_g ? z_ready : m_ready) == 4'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 32'((use_g ? z_ready : m_ready) != 4'b0), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n   = 1'b0;
    m_valid = 4'b0;
    g_valid = 4'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Counts grant pulses on dut_m and checks that each one is one-hot.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      ready_pulses = 0;
    end else if (m_ready != 4'b0) begin
      ready_pulses++;
      checkOutput("m_ready_onehot", 32'($onehot(m_ready)), 32'd1);
    end
  end

  // Collects each dut_m frame from its SOF and compares it with the next
  // expected frame. It then checks the gap cycle and the following idle cycle.
  initial begin : frame_monitor
    frame_t     e;
    logic [6:0] got;
    logic [1:0] src;
    logic       aborted;
    logic       lane_ok;
    int         rp;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && m_txv === 1'b1 && m_sof === 1'b1) begin
        rp           = ready_pulses;
        ready_pulses = 0;
        got          = 7'b0;
        got[0]       = m_bit;
        src          = m_src;
        aborted      = 1'b0;
        lane_ok      = 1'b1;
        checkOutput("ready_pulses_per_frame", 32'(rp), 32'd1);
        for (int i = 1; i < 7; i++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          got[i] = m_bit;
          if (m_txv !== 1'b1 || m_sof !== 1'b0 || m_src !== src || m_busy !== 1'b1) lane_ok = 1'b0;
        end
        if (exp_frames.size() == 0) begin
          checkOutput("unexpected_frame", 32'd1, 32'd0);
        end else begin
          e = exp_frames.pop_front();
          checkOutput("frame_aborted", 32'(aborted), 32'(e.aborted));
          if (!aborted && !e.aborted) begin
            checkOutput("frame_src", 32'(src), 32'(e.src));
            checkOutput("frame_bits", 32'(got), 32'(e.cw));
            checkOutput("frame_lane", 32'(lane_ok), 32'd1);
            @(negedge clk);
            checkOutput("gap_cycle_valid_busy", 32'({m_txv, m_busy}), 32'b01);
            @(negedge clk);
            checkOutput("idle_cycle_valid_busy", 32'({m_txv, m_busy}), 32'b00);
            checkOutput("src_hold", 32'(m_src), 32'(e.src));
          end
        end
      end
    end
  end

  // Grant-order monitor for dut_z: order, one-hot and 8-cycle spacing.
  int z_last = -1;
  int z_idx;
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      z_last = -1;
    end else if (z_ready != 4'b0) begin
      checkOutput("rr_onehot", 32'($onehot(z_ready)), 32'd1);
      z_idx = 0;
      for (int i = 0; i < 4; i++) if (z_ready[i]) z_idx = i;
      if (exp_grants.size() == 0) checkOutput("rr_unexpected_grant", 32'd1, 32'd0);
      else checkOutput("rr_order", 32'(z_idx), 32'(exp_grants.pop_front()));
      if (z_last >= 0) checkOutput("rr_spacing", 32'(cycle - z_last), 32'd8);
      z_last = cycle;
    end
  end

  // Idle-run monitors: the count of tx_valid=0 cycles between the last bit
  // of one frame and the SOF of the next.
  int z_idle = 0, f_idle = 0;
  bit z_prev = 0, f_prev = 0;
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      z_prev = 0; z_idle = 0; f_prev = 0; f_idle = 0;
    end else begin
      if (z_txv === 1'b1) begin
        if (z_sof === 1'b1 && z_prev) checkOutput("gap0_idle_run", 32'(z_idle), 32'd1);
        z_prev = 1; z_idle = 0;
      end else if (z_prev) z_idle++;
      if (f_txv === 1'b1) begin
        if (f_sof === 1'b1 && f_prev) checkOutput("gap15_idle_run", 32'(f_idle), 32'd16);
        f_prev = 1; f_idle = 0;
      end else if (f_prev) f_idle++;
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [3:0] nibs [3];
    logic [6:0] cws  [3];
    int         n;
    nibs = '{4'h0, 4'hF, 4'h1};
    cws  = '{7'b0000000, 7'b1111111, 7'b0000111};

    rst_n   = 1'b0;
    en      = 1'b1;
    g_valid = 4'b0;
    g_data  = 16'h0;
    applyStimulus(4'b0001, 16'h000B);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outputs", 32'({m_ready, m_bit, m_txv, m_sof, m_src, m_busy}), 32'd0);

    // Single nibble 0xB from requester 0.
    $display("[TB] single nibble");
    pushFrame(2'd0, 7'b1010101, 1'b0);
    rst_n = 1'b1;
    waitGrant(1'b0, 40, "grant_single");
    applyStimulus(4'b0000, 16'h0);
    repeat (12) @(posedge clk);
    #1;

    // Codeword values, one grant each.
    $display("[TB] codeword values");
    for (int i = 0; i < 3; i++) begin
      pushFrame(2'd0, cws[i], 1'b0);
      applyStimulus(4'b0001, {12'h0, nibs[i]});
      waitGrant(1'b0, 40, "grant_codeword");
      applyStimulus(4'b0000, 16'h0);
      repeat (12) @(posedge clk);
      #1;
    end

    // Enable dropped during bit 3: the frame completes, then grants stop.
    $display("[TB] enable control");
    doReset();
    pushFrame(2'd0, 7'b0000111, 1'b0);
    applyStimulus(4'b1111, 16'h8421);
    waitGrant(1'b0, 40, "grant_en_first");
    repeat (3) @(posedge clk);
    #1 en = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_ready != 4'b0) n++;
    end
    checkOutput("no_grant_while_en_low", 32'(n), 32'd0);
    pushFrame(2'd1, 7'b0011001, 1'b0);
    @(posedge clk);
    #1 en = 1'b1;
    waitGrant(1'b0, 40, "grant_en_resume");
    applyStimulus(4'b0000, 16'h0);
    repeat (12) @(posedge clk);
    #1;

    // Reset during bit 4, then requesters 1 and 3 compete from rr_ptr=0.
    $display("[TB] reset mid-frame");
    doReset();
    pushFrame(2'd0, 7'b0101101, 1'b1);
    applyStimulus(4'b0001, 16'h0005);
    waitGrant(1'b0, 40, "grant_before_reset");
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("reset_midframe_outputs",
                   32'({m_ready, m_bit, m_txv, m_sof, m_src, m_busy}), 32'd0);
    pushFrame(2'd1, 7'b0110011, 1'b0);
    pushFrame(2'd3, 7'b1001100, 1'b0);
    applyStimulus(4'b1010, 16'h9060);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 checkOutput("first_grant_after_reset", 32'(m_ready), 32'b0010);
    waitGrant(1'b0, 40, "grant_after_reset_1");
    waitGrant(1'b0, 40, "grant_after_reset_3");
    applyStimulus(4'b0000, 16'h0);
    repeat (12) @(posedge clk);
    #1;

    // Round robin and gap length on the GAP=0 and GAP=15 instances.
    $display("[TB] round robin and gap length");
    doReset();
    exp_grants = '{0, 1, 2, 3, 0, 1, 3, 0, 1};
    g_data  = 16'hA965;
    g_valid = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      waitGrant(1'b1, 40, "grant_rr");
      if (i == 5) g_valid = 4'b1011;
    end
    g_valid = 4'b0000;
    repeat (40) @(posedge clk);
    #1;

    checkOutput("frames_left", 32'(exp_frames.size()), 32'd0);
    checkOutput("grants_left", 32'(exp_grants.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hamming_tx_scheduler.md
# hamming_tx_scheduler

Round-robin scheduler that shares one Hamming(7,4) encoder among `NUM_REQ` nibble sources and serializes each resulting codeword onto a single-bit transmit lane. It sits between the producer blocks and the line interface. It arbitrates valid/ready requests, captures one 4-bit nibble per grant, and encodes it with the team's `hamming_encoder` instance. It then shifts out the 7-bit codeword LSB-first with a start-of-frame marker and a programmable inter-frame gap.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `GAP_CYCLES`, default 1: idle cycles after each frame's last bit, range 0..15.
- `SRC_W`, default `$clog2(NUM_REQ)`: width of `tx_src`. Derived; not overridden.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  scheduler enable. When low, no new grants are issued.
- `req_valid`  in  NUM_REQ  per-requester valid.
- `req_data`  in  4*NUM_REQ  nibble for requester i at bits [4i+3:4i].
- `req_ready`  out  NUM_REQ  one-hot grant/ready, at most one bit high.
- `tx_bit`  out  1  serial codeword bit.
- `tx_valid`  out  1  high while `tx_bit` carries a codeword bit.
- `tx_sof`  out  1  high with codeword bit 0 only.
- `tx_src`  out  SRC_W  index of the requester whose frame is on the lane.
- `busy`  out  1  high in SHIFT or GAP.

## Operation
- States: IDLE, SHIFT, GAP.
- **Reset values** (async, immediate on `rst_n` low):
  - state IDLE, `rr_ptr`=0, bit counter 0, shift register 0.
  - All outputs 0.
- **IDLE:**
  - If `en`=1 and any `req_valid` is high, grant = first i with `req_valid[i]`=1, searching cyclically from `rr_ptr`.
  - `req_ready[grant]`=1 combinationally in the same cycle. This is the only cycle in which `req_ready` can be high.
  - On that edge:
    - capture `hamming_encoder(req_data[grant])` into a 7-bit shift register;
    - `tx_src`<=grant;
    - `rr_ptr`<=(grant+1) mod NUM_REQ;
    - go to SHIFT with counter 0.
  - If `en`=0 or no request is valid, remain in IDLE with `req_ready`=0.
- **Codeword layout**, fixed:
  - cw[0]=d0^d1^d3, cw[1]=d0^d2^d3, cw[2]=d0, cw[3]=d1^d2^d3;
  - cw[4]=d1, cw[5]=d2, cw[6]=d3, where d = captured nibble.
- **SHIFT:**
  - Outputs are registered: `tx_bit`=cw[counter], `tx_valid`=1, `tx_sof`=(counter==0).
  - Counter increments by 1 each cycle, 0..6.
  - After counter 6: go to GAP if `GAP_CYCLES`>0, else to IDLE.
- **GAP:** `tx_valid`=0 for exactly `GAP_CYCLES` cycles, then go to IDLE.
- **`en` deassertion** mid-frame does not abort the frame. The frame and its gap complete, and the scheduler then holds in IDLE.
- **Requester behaviour:** a requester that drops `req_valid` before being granted is simply skipped. `req_data` is sampled only on the grant cycle.
- **`rr_ptr`** advances only on a grant. An ungranted requester keeps its priority position.
- **`busy`**=1 in SHIFT and GAP, 0 in IDLE.
- **`tx_src`** holds its last value after the frame ends.

## Timing
- Grant cycle T (IDLE, handshake):
  - `tx_bit`=cw[0] with `tx_sof`=1 in cycle T+1;
  - cw[6] in T+7;
  - gap in T+8..T+7+GAP_CYCLES;
  - IDLE in T+8+GAP_CYCLES.
- The next grant can occur in cycle T+8+GAP_CYCLES, so the back-to-back frame period is 8+GAP_CYCLES cycles.
- Handshake-to-first-bit latency is 1 cycle.
- With continuous requests there is exactly 1 cycle with `tx_valid`=0 between frames when GAP_CYCLES=0. That cycle is the IDLE grant cycle.
- **Reset asserted mid-frame:**
  - The frame is aborted immediately and `tx_valid`, `tx_sof` and `req_ready` go to 0.
  - The nibble is discarded; there is no resumption.
  - After `rst_n` rises, the first possible grant is at the first rising edge, with `rr_ptr`=0.
- **Simultaneous requests:** all requesters valid in the same cycle are served in strict rotation starting from `rr_ptr`.

## Test plan
- **Single nibble.** Requester 0 sends 0xB with GAP_CYCLES=1.
  - Required response: `tx_bit` sequence 1,0,1,0,1,0,1 over T+1..T+7, `tx_sof` only at T+1, `tx_src`=0, `tx_valid`=0 at T+8, `busy`=0 at T+9.
- **Codeword values.**
  - 0x0 gives 0,0,0,0,0,0,0.
  - 0xF gives 1,1,1,1,1,1,1.
  - 0x1 gives 1,1,1,0,0,0,0.
  - Each frame must be preceded by exactly one `req_ready` pulse.
- **Round-robin fairness.** All 4 requesters are continuously valid with GAP_CYCLES=0.
  - Grants follow order 0,1,2,3,0 at 8-cycle spacing, and `req_ready` is always one-hot.
  - Then drop requester 2 after grant 1: order becomes 0,1,3,0,1.
- **Enable control.**
  - Drop `en` during bit 3 of a frame: the frame completes all 7 bits and no further grant occurs while `en`=0.
  - Raise `en`: grant resumes from `rr_ptr`.
- **Reset mid-frame.** Assert `rst_n`=0 during bit 4.
  - Outputs are 0 in the same cycle.
  - After release, with requesters 1 and 3 valid, requester 1 is granted first.
- **Gap length.**
  - GAP_CYCLES=15: exactly 15 `tx_valid`=0 cycles plus the 1 IDLE grant cycle between frames.
  - GAP_CYCLES=0: exactly 1 such cycle.
